// File: rtl/jk_pkg.sv
// jk_pkg: shared op encodings, command widths, FSM states and JK next-state helper
package jk_pkg;
  localparam int CMD_LEN_W = 4;
  localparam int CMD_W = 2 + CMD_LEN_W;
  typedef enum logic [1:0] {OP_HOLD = 2'b00, OP_RESET = 2'b01, OP_SET = 2'b10, OP_TOGGLE = 2'b11} op_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  function automatic logic jk_next(input logic j, input logic k, input logic q);
    return (j && k) ? !q : j ? 1'b1 : k ? 1'b0 : q;
  endfunction
endpackage

// File: rtl/jk_cmd_fifo.sv
// jk_cmd_fifo: synchronous show-ahead command queue with full/empty flags
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  assign full = wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]};
  assign empty = wr_ptr_q == rd_ptr_q;
  assign dout = mem_q[rd_ptr_q[AW-1:0]];
  // pointers carry an extra wrap bit so full and empty are distinguishable
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en && !full);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en && !empty);
  end
  // pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // storage is not reset; the pointers define which entries are valid
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues JK commands, drives j/k for each command's duration and checks q feedback
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CMD_LEN_W-1:0] cmd_len,
  output logic                 j,
  output logic                 k,
  input  logic                 q_fb,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch
);
  logic [CMD_W-1:0] f_dout, pend_q, pend_d;
  logic f_full, f_empty, f_rd, last, take;
  logic pend_v_q, pend_v_d, rdy_q, chk_q;
  logic j_q, j_d, k_q, k_d, done_q, done_d, q_exp_q, q_exp_d, mismatch_q, mismatch_d;
  logic [CMD_LEN_W-1:0] cnt_q, cnt_d;
  state_e state_q, state_d;
  jk_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(cmd_valid && cmd_ready), .din({cmd_op, cmd_len}),
    .rd_en(f_rd), .dout(f_dout), .full(f_full), .empty(f_empty)
  );
  assign cmd_ready = rst_n && rdy_q && !f_full;
  assign {j, k, done, mismatch} = {j_q, k_q, done_q, mismatch_q};
  assign busy = state_q == RUN || !f_empty || pend_v_q;
  // a one-entry staging register holds the next popped command so the following command starts with no gap
  always_comb begin
    last = state_q == IDLE || cnt_q == '0;
    take = last && pend_v_q;
    f_rd = !f_empty && (!pend_v_q || take);
    pend_v_d = f_rd || (pend_v_q && !take);
    pend_d = f_rd ? f_dout : pend_q;
    state_d = last ? (pend_v_q ? RUN : IDLE) : RUN;
    {j_d, k_d} = last ? (pend_v_q ? pend_q[CMD_W-1 -: 2] : 2'b00) : {j_q, k_q};
    cnt_d = last ? pend_q[CMD_LEN_W-1:0] : cnt_q - 1'b1;
    done_d = last ? (pend_v_q && pend_q[CMD_LEN_W-1:0] == '0) : cnt_q == CMD_LEN_W'(1);
    q_exp_d = jk_next(j_q, k_q, q_exp_q);
    mismatch_d = mismatch_q || (chk_q && q_fb != q_exp_q);
  end
  // FSM and registered outputs; checking starts one cycle after reset release
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= '0;
      pend_v_q <= 1'b0;
      {j_q, k_q, done_q} <= 3'b000;
      q_exp_q <= 1'b0;
      mismatch_q <= 1'b0;
      chk_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      {j_q, k_q, done_q} <= {j_d, k_d, done_d};
      q_exp_q <= q_exp_d;
      mismatch_q <= mismatch_d;
      chk_q <= 1'b1;
      rdy_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: randomized scoreboard bench with a cycle-schedule reference model
module tb_jk_cmd_sequencer;
  import jk_pkg::*;
  logic clk = 0, rst_n = 0, cmd_valid = 0, flip = 0, q_m = 0;
  logic [1:0] cmd_op = 0;
  logic [3:0] cmd_len = 0;
  logic cmd_ready, j, k, q_fb, busy, done, mismatch;
  int tests = 0, fails = 0, e = 0, last_end = 0, dn_cnt = 0;
  bit [1:0] ejk [8192];
  bit edn [8192], ebz [8192];
  bit exp_mm = 0, chk_m = 0, saw_low = 0;
  bit [1:0] expq [$];

  jk_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .j(j), .k(k), .q_fb(q_fb), .busy(busy), .done(done), .mismatch(mismatch)
  );

  always #5 clk = ~clk;
  assign q_fb = q_m ^ flip;
  always @(posedge clk) q_m <= !rst_n ? 1'b0 : jk_next(j, k, q_m);

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, e, act, exp);
    end
  endtask

  // reference schedule: a command accepted at edge n starts at max(n+2, previous end+1) and lasts len+1 cycles
  always @(posedge clk) begin
    int s;
    e = e + 1;
    if (!rst_n) begin
      for (int i = e; i < e + 256; i++) begin
        ejk[i] = 0; edn[i] = 0; ebz[i] = 0;
      end
      last_end = e;
      expq.delete();
      exp_mm = 0;
      chk_m = 0;
    end else begin
      if (chk_m && flip) exp_mm = 1;
      chk_m = 1;
      if (cmd_valid && cmd_ready) begin
        s = (e + 2 > last_end + 1) ? e + 2 : last_end + 1;
        for (int i = 0; i <= int'(cmd_len); i++) begin
          ejk[s+i] = cmd_op;
          edn[s+i] = (i == int'(cmd_len));
        end
        for (int i = e; i <= s + int'(cmd_len); i++) ebz[i] = 1;
        last_end = s + int'(cmd_len);
        expq.push_back(cmd_op);
      end
    end
  end

  always @(negedge clk) begin
    check("jk", {j, k}, ejk[e]);
    check("done", done, edn[e]);
    check("busy", busy, ebz[e]);
    check("mismatch", mismatch, exp_mm);
    if (!rst_n) check("ready_in_reset", cmd_ready, 0);
    if (rst_n && busy && !cmd_ready) saw_low = 1;
    if (done) begin
      dn_cnt++;
      if (expq.size() == 0) check("order_underflow", 1, 0);
      else check("order", {j, k}, expq.pop_front());
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] len);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_len = len;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("send_timeout", 0, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 0; cmd_op = 2'($urandom); cmd_len = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    idle();
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("idle_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_toggle();
    int n = 0;
    while (!(j && k) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("toggle_timeout", 0, 1);
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    check("ready_low_reset", cmd_ready, 0);
    rst_n = 1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);
    send(OP_SET, 2);
    wait_idle();
    check("q_after_set", q_fb, 1);
    send(OP_SET, 0); send(OP_TOGGLE, 3); send(OP_RESET, 1);
    wait_idle();
    check("q_after_seq", q_fb, 0);
    saw_low = 0;
    send(OP_SET, 15);
    for (int i = 0; i < 7; i++) send(2'($urandom), 4'($urandom_range(0, 3)));
    wait_idle();
    check("ready_low_when_full", saw_low, 1);
    d0 = dn_cnt;
    for (int i = 0; i < 20; i++) send(2'($urandom), 0);
    wait_idle();
    check("stream_done_count", dn_cnt - d0, 20);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send(2'($urandom), 4'($urandom_range(0, 4)));
    end
    wait_idle();
    send(OP_TOGGLE, 5);
    idle();
    wait_toggle();
    flip = 1;
    @(negedge clk);
    flip = 0;
    wait_idle();
    check("mismatch_sticky", mismatch, 1);
    send(OP_TOGGLE, 9); send(OP_SET, 3); send(OP_RESET, 2);
    idle();
    wait_toggle();
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("abort_jk", {j, k}, 0);
    check("abort_busy", busy, 0);
    check("abort_mismatch", mismatch, 0);
    rst_n = 1;
    @(negedge clk);
    check("ready_after_release", cmd_ready, 1);
    repeat (30) @(negedge clk);
    check("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
